// File: rtl/d_latch.sv
// d_latch: WIDTH-bit level-sensitive latch bank with asynchronous active-low clear.
// Defining DLATCH_QN_EN adds a complement output qn after rst_n.
`timescale 1ns/100ps
module d_latch #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit              GATE_POL  = 1'b1
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             clk,
    input  logic             rst_n
`ifdef DLATCH_QN_EN
    ,
    output logic [WIDTH-1:0] qn
`endif
);
    // Intentional latch: clear dominates, gate level opens the latch
    always_latch
        if (!rst_n) q <= RESET_VAL;
        else if (clk == GATE_POL) q <= d;
`ifdef DLATCH_QN_EN
    assign qn = ~q;
`endif
endmodule

// File: tb/tb_d_latch.sv
// tb_d_latch: vector table, hand-written corner sequences and randomized checks for d_latch.
`timescale 1ns/100ps
module tb_d_latch;
    typedef struct {
        logic       rst_n;
        logic       g;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic tog = 1'b0;
    logic man = 1'b0;
    logic use_tog = 1'b0;
    logic g1;
    logic d1 = 1'b0;
    logic rst1 = 1'b0;
    logic q1;
    logic g2 = 1'b1;
    logic rst2 = 1'b0;
    logic [7:0] d2 = '0;
    logic [7:0] q2;
`ifdef DLATCH_QN_EN
    logic qn1;
    logic [7:0] qn2;
`endif

    always #1 tog = ~tog;
    assign g1 = use_tog ? tog : man;

    d_latch u1 (
        .q(q1), .d(d1), .clk(g1), .rst_n(rst1)
`ifdef DLATCH_QN_EN
        , .qn(qn1)
`endif
    );

    d_latch #(.WIDTH(8), .RESET_VAL(8'hC3), .GATE_POL(1'b0)) u2 (
        .q(q2), .d(d2), .clk(g2), .rst_n(rst2)
`ifdef DLATCH_QN_EN
        , .qn(qn2)
`endif
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        vec_t tbl[10];
        logic [7:0] m;
        logic [7:0] pat;
        tbl[0] = '{1'b0, 1'b1, 8'hFF, 8'hC3};
        tbl[1] = '{1'b1, 1'b1, 8'hFF, 8'hC3};
        tbl[2] = '{1'b1, 1'b0, 8'hA5, 8'hA5};
        tbl[3] = '{1'b1, 1'b1, 8'h3C, 8'hA5};
        tbl[4] = '{1'b1, 1'b1, 8'h00, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 8'h00, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 8'h81, 8'h81};
        tbl[7] = '{1'b0, 1'b0, 8'h81, 8'hC3};
        tbl[8] = '{1'b1, 1'b0, 8'h7E, 8'h7E};
        tbl[9] = '{1'b1, 1'b1, 8'h11, 8'h7E};

        // Reset held while the gate toggles
        use_tog = 1'b1;
        d1 = 1'b1;
        rst1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #0.7;
            chk("reset_hold", {7'b0, q1}, 8'h00);
`ifdef DLATCH_QN_EN
            chk("reset_qn", {7'b0, qn1}, 8'h01);
`endif
        end
        use_tog = 1'b0;
        man = 1'b1;
        #0.5;
        rst1 = 1'b1;
        #0.1;
        chk("release_active", {7'b0, q1}, 8'h01);

        // Transparency sequence with the free-running gate
        pat = 8'b00110;
        use_tog = 1'b1;
        @(negedge tog);
        #0.5;
        for (int i = 4; i >= 0; i--) begin
            d1 = pat[i];
            #2.9;
            chk("transparent", {7'b0, q1}, {7'b0, pat[i]});
`ifdef DLATCH_QN_EN
            chk("transparent_qn", {7'b0, qn1}, {7'b0, ~pat[i]});
`endif
            #0.1;
        end
        use_tog = 1'b0;

        // Hold while gate is closed
        man = 1'b1; d1 = 1'b1;
        #0.5;
        chk("hold_open", {7'b0, q1}, 8'h01);
        man = 1'b0;
        #0.5;
        d1 = 1'b0;
        #5;
        chk("hold_closed", {7'b0, q1}, 8'h01);
        man = 1'b1;
        #0.1;
        chk("hold_reopen", {7'b0, q1}, 8'h00);

        // Asynchronous clear in the middle of a hold
        d1 = 1'b1;
        #0.5;
        man = 1'b0;
        #0.5;
        rst1 = 1'b0;
        #0.1;
        chk("async_clr", {7'b0, q1}, 8'h00);
        #0.9;
        rst1 = 1'b1;
        #0.5;
        chk("clr_release_closed", {7'b0, q1}, 8'h00);
        man = 1'b1;
        #0.1;
        chk("clr_then_open", {7'b0, q1}, 8'h01);

        // Vector table on the 8-bit active-low-gate instance
        for (int i = 0; i < 10; i++) begin
            rst2 = tbl[i].rst_n;
            g2 = tbl[i].g;
            d2 = tbl[i].d;
            #1;
            chk($sformatf("vec%0d", i), q2, tbl[i].exp);
`ifdef DLATCH_QN_EN
            chk($sformatf("vec%0d_qn", i), qn2, ~tbl[i].exp);
`endif
        end

        // Randomized stimulus against a rule-level model
        m = q2;
        for (int i = 0; i < 300; i++) begin
            rst2 = ($urandom_range(7) != 0);
            g2 = $urandom_range(1);
            d2 = 8'($urandom);
            #1;
            m = !rst2 ? 8'hC3 : (g2 == 1'b0 ? d2 : m);
            chk("random", q2, m);
`ifdef DLATCH_QN_EN
            chk("random_qn", qn2, ~m);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
